// File: rtl/dark_channel_atm_light_if.sv
// Bundle of the window input bus and the dark-channel / atmospheric-light results.
interface dark_channel_atm_light_if;
  logic [71:0] red_window_in;
  logic [71:0] green_window_in;
  logic [71:0] blue_window_in;
  logic        input_is_valid;
  logic [7:0]  dark_channel;
  logic [23:0] center_pixel;
  logic        output_is_valid;
  logic [23:0] atm_light;
  logic        atm_light_valid;

  // Window source side: drives the windows, receives the results
  modport master (
    output red_window_in, green_window_in, blue_window_in, input_is_valid,
    input  dark_channel, center_pixel, output_is_valid, atm_light, atm_light_valid
  );

  // Processing side: consumes the windows, produces the results
  modport slave (
    input  red_window_in, green_window_in, blue_window_in, input_is_valid,
    output dark_channel, center_pixel, output_is_valid, atm_light, atm_light_valid
  );
endinterface

// File: rtl/dark_channel_atm_light.sv
// Three-stage 3x3 dark-channel pipeline with a per-frame atmospheric-light tracker.
// The tracker remembers the centre pixel of the window with the brightest dark
// value (earliest wins on ties) and publishes it when the frame's last window
// leaves the pipeline.
module dark_channel_atm_light #(
  parameter int FRAME_WINDOWS = 262144,
  parameter int CNT_W         = 20
) (
  input logic                   clk,
  input logic                   rst,
  dark_channel_atm_light_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [2:0]      valid_pipe;
  logic [8:0][7:0] m_d;
  logic [8:0][7:0] m_q;
  logic [23:0]     center_in;
  logic [23:0]     c1_q;
  logic [2:0][7:0] row_q;
  logic [23:0]     c2_q;
  logic [7:0]      dark_q;
  logic [23:0]     center_q;

  state_t          state;
  state_t          state_next;
  logic [CNT_W-1:0] win_cnt;
  logic [7:0]      max_dark;
  logic [23:0]     cand;
  logic [23:0]     atm_q;
  logic            beats_max;
  logic [7:0]      max_post;
  logic [23:0]     cand_post;
  logic            last_win;
  logic            atm_valid;

  assign center_in = {bus.red_window_in[39:32], bus.green_window_in[39:32],
                      bus.blue_window_in[39:32]};

  // Per-element minimum across the three colour planes
  always_comb begin
    m_d = '0;
    for (int k = 0; k < 9; k++) begin
      m_d[k] = min2(min2(bus.red_window_in[8*k +: 8], bus.green_window_in[8*k +: 8]),
                    bus.blue_window_in[8*k +: 8]);
    end
  end

  // Valid shift register; a reset flushes anything in flight
  always_ff @(posedge clk) begin
    if (rst) valid_pipe <= '0;
    else     valid_pipe <= {valid_pipe[1:0], bus.input_is_valid};
  end

  // Stage 1: element minima and centre pixel, loaded only for valid windows
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q  <= '0;
      c1_q <= '0;
    end else if (bus.input_is_valid) begin
      m_q  <= m_d;
      c1_q <= center_in;
    end
  end

  // Stage 2: row minima
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      c2_q  <= '0;
    end else if (valid_pipe[0]) begin
      row_q[0] <= min2(min2(m_q[0], m_q[1]), m_q[2]);
      row_q[1] <= min2(min2(m_q[3], m_q[4]), m_q[5]);
      row_q[2] <= min2(min2(m_q[6], m_q[7]), m_q[8]);
      c2_q     <= c1_q;
    end
  end

  // Stage 3: final window minimum
  always_ff @(posedge clk) begin
    if (rst) begin
      dark_q   <= '0;
      center_q <= '0;
    end else if (valid_pipe[1]) begin
      dark_q   <= min2(min2(row_q[0], row_q[1]), row_q[2]);
      center_q <= c2_q;
    end
  end

  assign beats_max = (dark_q > max_dark);
  assign max_post  = beats_max ? dark_q : max_dark;
  assign cand_post = beats_max ? center_q : cand;
  assign last_win  = (win_cnt == CNT_W'(FRAME_WINDOWS - 1));

  // Tracker state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Tracker next-state decision
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_pipe[2]) state_next = ACCUM;
      ACCUM:   if (valid_pipe[2] && last_win) state_next = DONE;
      DONE:    state_next = valid_pipe[2] ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Tracker outputs: the frame-end pulse lasts for the single DONE cycle
  always_comb begin
    atm_valid = 1'b0;
    if (state == DONE) atm_valid = 1'b1;
  end

  // Tracker datapath: window count, running maximum and published result
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      max_dark <= '0;
      cand     <= '0;
      atm_q    <= '0;
    end else if (valid_pipe[2]) begin
      if (state == ACCUM && last_win) begin
        atm_q    <= cand_post;
        win_cnt  <= '0;
        max_dark <= '0;
        cand     <= '0;
      end else if (state == ACCUM) begin
        win_cnt  <= win_cnt + CNT_W'(1);
        max_dark <= max_post;
        cand     <= cand_post;
      end else begin
        win_cnt  <= CNT_W'(1);
        max_dark <= max_post;
        cand     <= cand_post;
      end
    end
  end

  assign bus.dark_channel    = dark_q;
  assign bus.center_pixel    = center_q;
  assign bus.output_is_valid = valid_pipe[2];
  assign bus.atm_light       = atm_q;
  assign bus.atm_light_valid = atm_valid;

endmodule

// File: doc/dark_channel_atm_light.md
DARK_CHANNEL_ATM_LIGHT -- requirements
Module: dark_channel_atm_light

Interface
REQ-001 Parameter: FRAME_WINDOWS, default 262144, number of valid windows per frame (must be >= 2).
REQ-002 Parameter: CNT_W, default 20, width of the window counter (must satisfy 2^CNT_W >= FRAME_WINDOWS).
REQ-003 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: red_window_in  input  72  3x3 red window; element k in bits [8k+7:8k], k=0..8, k=4 is the centre.
REQ-006 Port: green_window_in  input  72  3x3 green window, same layout.
REQ-007 Port: blue_window_in  input  72  3x3 blue window, same layout.
REQ-008 Port: input_is_valid  input  1  windows valid this cycle; no backpressure.
REQ-009 Port: dark_channel  output  8  min over the 9 elements of min(R,G,B).
REQ-010 Port: center_pixel  output  24  centre RGB {R[4],G[4],B[4]}, aligned with dark_channel.
REQ-011 Port: output_is_valid  output  1  dark_channel and center_pixel valid.
REQ-012 Port: atm_light  output  24  atmospheric light RGB of the last completed frame.
REQ-013 Port: atm_light_valid  output  1  one-cycle pulse when atm_light updates.

Function
REQ-014 Stage 1 SHALL register, for each k, m[k] = min(R[k],G[k],B[k]), the centre pixel, and the valid bit.
REQ-015 Stage 2 SHALL register the row minima min(m0,m1,m2), min(m3,m4,m5) and min(m6,m7,m8), plus the centre pixel and valid.
REQ-016 Stage 3 SHALL register dark_channel = min of the three row minima, plus center_pixel and output_is_valid.
REQ-017 Latency from input_is_valid to output_is_valid SHALL be exactly 3 cycles; the valid pipe is a 3-bit shift register.
REQ-018 Data registers SHALL load only when their stage valid is high; they hold otherwise.
REQ-019 Input bubbles SHALL propagate as output_is_valid=0 bubbles, with no reordering.
REQ-020 All comparisons SHALL be unsigned 8-bit; no widening.
REQ-021 The tracker SHALL hold max_dark (8 bits), cand (24 bits) and win_cnt (CNT_W bits).
REQ-022 On each output_is_valid, if dark_channel > max_dark (strict), the tracker SHALL set max_dark to dark_channel and cand to center_pixel.
REQ-023 On ties, the tracker SHALL keep the earliest window.
REQ-024 FSM states: IDLE, ACCUM, DONE.
REQ-025 IDLE: the first output_is_valid processes window 0 and moves to ACCUM.
REQ-026 ACCUM: each output_is_valid increments win_cnt.
REQ-027 ACCUM: when output_is_valid is high and win_cnt == FRAME_WINDOWS-1, the FSM SHALL move to DONE.
REQ-028 On the ACCUM-to-DONE transition, atm_light SHALL be loaded with the post-compare candidate, so the final window is included.
REQ-029 On the ACCUM-to-DONE transition, win_cnt, max_dark and cand SHALL clear to 0.
REQ-030 DONE SHALL last exactly one cycle, with atm_light_valid=1.
REQ-031 In DONE, an output_is_valid SHALL count as window 0 of the next frame, update max_dark and cand, set win_cnt=1, and go to ACCUM.
REQ-032 In DONE with no output_is_valid, the FSM SHALL go to IDLE.
REQ-033 atm_light SHALL hold its value between frame ends.
REQ-034 atm_light_valid SHALL be 0 in IDLE and ACCUM.
REQ-035 A frame whose maximum dark value is 0 SHALL yield atm_light = 0.

Reset
REQ-036 While rst is high: valid pipe=0, output_is_valid=0, atm_light_valid=0, FSM=IDLE, win_cnt=0, max_dark=0, cand=0, atm_light=0.
REQ-037 dark_channel and center_pixel SHALL reset to 0.
REQ-038 A reset mid-frame SHALL discard the partial frame with no atm_light_valid pulse.
REQ-039 Windows in flight at reset SHALL never assert output_is_valid.
REQ-040 The first valid after reset release SHALL be window 0.

Verification
REQ-041 Single window, R=G=B=8'h80 except element 7 with B=8'h12 -> 3 cycles later dark_channel=8'h12, center_pixel=24'h808080, output_is_valid high for 1 cycle.
REQ-042 Valid pattern 1,0,1,1 -> output_is_valid pattern 1,0,1,1 starting 3 cycles later, with matching data.
REQ-043 FRAME_WINDOWS=4 with dark values 10,30,30,5 and centres A,B,C,D -> atm_light=B, a single atm_light_valid pulse 1 cycle after the 4th output_is_valid.
REQ-044 FRAME_WINDOWS=4 with dark values 1,2,3,200 (last window largest, centre 24'hF0E0D0) -> atm_light=24'hF0E0D0.
REQ-045 FRAME_WINDOWS=4, continuous valid across 2 frames -> 2 pulses 4 cycles apart, with the frame-2 window 0 counted during DONE.
REQ-046 rst asserted after 2 windows of a frame -> no pulse, atm_light=0; the next 4 windows produce a normal pulse.
